// File: rtl/float_add_sub_p.sv
// Pipelined floating-point adder/subtractor.
// Four en_i-qualified stages: swap, align, add, then normalise/round with saturation and flush-to-zero.
module float_add_sub_p #(
  parameter  int unsigned EXP_W = 5,
  parameter  int unsigned MAN_W = 6,
  localparam int unsigned W     = 1 + EXP_W + MAN_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         en_i,
  input  logic         valid_i,
  input  logic         sub_i,
  input  logic [W-1:0] data_1_i,
  input  logic [W-1:0] data_2_i,
  output logic         valid_o,
  output logic [W-1:0] data_sum_o,
  output logic         ovf_o,
  output logic         unf_o
);

  localparam int unsigned SW      = MAN_W + 4;
  localparam int unsigned EW      = EXP_W + 2;
  localparam int unsigned SH_W    = $clog2(SW);
  localparam int unsigned EXP_MAX = (1 << EXP_W) - 1;

  // Stage 1 inputs: effective sign of b, hidden-bit significands, magnitude order.
  logic             sign_a, sign_b, nz_a, nz_b, a_big;
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W:0]   sig_a, sig_b;

  assign sign_a = data_1_i[W-1];
  assign sign_b = data_2_i[W-1] ^ sub_i;
  assign exp_a  = data_1_i[W-2:MAN_W];
  assign exp_b  = data_2_i[W-2:MAN_W];
  assign nz_a   = |exp_a;
  assign nz_b   = |exp_b;
  assign sig_a  = {nz_a, data_1_i[MAN_W-1:0] & {MAN_W{nz_a}}};
  assign sig_b  = {nz_b, data_2_i[MAN_W-1:0] & {MAN_W{nz_b}}};
  assign a_big  = data_1_i[W-2:0] >= data_2_i[W-2:0];

  logic             s1_valid, s1_sign_l, s1_sign_s;
  logic [EXP_W-1:0] s1_exp_l, s1_exp_s;
  logic [MAN_W:0]   s1_sig_l, s1_sig_s;

  logic             s2_valid, s2_sign, s2_eff_sub;
  logic [EXP_W-1:0] s2_exp;
  logic [SW-1:0]    s2_sig_l, s2_sig_s;

  logic             s3_valid, s3_sign;
  logic [EXP_W-1:0] s3_exp;
  logic [SW:0]      s3_sum;

  // Stage 2 alignment: shift smaller significand right, folding lost bits into sticky.
  logic [EXP_W-1:0] diff;
  logic [SW-1:0]    ext, shifted;
  logic             sticky;

  assign diff = s1_exp_l - s1_exp_s;
  assign ext  = {s1_sig_s, 3'b000};

  always_comb begin
    shifted = '0;
    sticky  = 1'b0;
    if (32'(diff) >= MAN_W + 3) begin
      shifted[0] = |s1_sig_s;
    end else begin
      for (int unsigned i = 0; i < SW; i++) begin
        if (i < 32'(diff)) sticky = sticky | ext[i];
      end
      shifted    = ext >> diff;
      shifted[0] = shifted[0] | sticky;
    end
  end

  // Stage 4: leading-one detect, normalise, round to nearest even, range check.
  logic [SH_W-1:0]  lz;
  logic [SW-1:0]    norm;
  logic [EW-1:0]    exp_n, exp_f;
  logic [MAN_W+1:0] man_r;
  logic [MAN_W-1:0] man_f;
  logic             rnd_up, zero_c, ovf_c, unf_c;
  logic [W-1:0]     res_c;

  always_comb begin
    lz = '0;
    for (int unsigned i = 0; i < SW; i++) begin
      if (s3_sum[i]) lz = SH_W'(SW - 1 - i);
    end
    if (s3_sum[SW]) begin
      norm  = {s3_sum[SW:2], |s3_sum[1:0]};
      exp_n = {2'b00, s3_exp} + EW'(1);
    end else begin
      norm  = s3_sum[SW-1:0] << lz;
      exp_n = {2'b00, s3_exp} - EW'(lz);
    end
    rnd_up = norm[2] & (norm[1] | norm[0] | norm[3]);
    man_r  = {1'b0, norm[SW-1:3]} + (MAN_W+2)'(rnd_up);
    man_f  = man_r[MAN_W+1] ? man_r[MAN_W:1] : man_r[MAN_W-1:0];
    exp_f  = exp_n + EW'(man_r[MAN_W+1]);
    zero_c = (s3_sum == '0);
    ovf_c  = !zero_c && !exp_f[EW-1] && (exp_f > EW'(EXP_MAX));
    unf_c  = !zero_c && (exp_f[EW-1] || (exp_f == '0));
    if (zero_c || unf_c) begin
      res_c = '0;
    end else if (ovf_c) begin
      res_c = {s3_sign, {(W-1){1'b1}}};
    end else begin
      res_c = {s3_sign, exp_f[EXP_W-1:0], man_f};
    end
  end

  // Valid chain and output registers; reset wins over en_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid   <= 1'b0;
      s2_valid   <= 1'b0;
      s3_valid   <= 1'b0;
      valid_o    <= 1'b0;
      data_sum_o <= '0;
      ovf_o      <= 1'b0;
      unf_o      <= 1'b0;
    end else if (en_i) begin
      s1_valid <= valid_i;
      s2_valid <= s1_valid;
      s3_valid <= s2_valid;
      valid_o  <= s3_valid;
      if (s3_valid) begin
        data_sum_o <= res_c;
        ovf_o      <= ovf_c;
        unf_o      <= unf_c;
      end
    end
  end

  // Datapath stage registers; free to toggle on invalid slots.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      s1_sign_l  <= a_big ? sign_a : sign_b;
      s1_sign_s  <= a_big ? sign_b : sign_a;
      s1_exp_l   <= a_big ? exp_a : exp_b;
      s1_exp_s   <= a_big ? exp_b : exp_a;
      s1_sig_l   <= a_big ? sig_a : sig_b;
      s1_sig_s   <= a_big ? sig_b : sig_a;

      s2_sign    <= s1_sign_l;
      s2_eff_sub <= s1_sign_l ^ s1_sign_s;
      s2_exp     <= s1_exp_l;
      s2_sig_l   <= {s1_sig_l, 3'b000};
      s2_sig_s   <= shifted;

      s3_sign    <= s2_sign;
      s3_exp     <= s2_exp;
      s3_sum     <= s2_eff_sub ? ({1'b0, s2_sig_l} - {1'b0, s2_sig_s})
                               : ({1'b0, s2_sig_l} + {1'b0, s2_sig_s});
    end
  end

endmodule

// File: tb/tb_float_add_sub_p.sv
// Bench for float_add_sub_p at default widths (12-bit words).
// Expected results come from an exact-integer reference model queued at issue time.
module tb_float_add_sub_p;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        en_i = 1'b1;
  logic        valid_i = 1'b0;
  logic        sub_i = 1'b0;
  logic [11:0] data_1_i = '0;
  logic [11:0] data_2_i = '0;
  logic        valid_o, ovf_o, unf_o;
  logic [11:0] data_sum_o;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  logic        last_en = 1'b0;
  logic [13:0] exp_q[$];
  int          cyc_q[$];
  logic [13:0] last_out = '0;

  float_add_sub_p #(.EXP_W(5), .MAN_W(6)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .valid_i(valid_i), .sub_i(sub_i),
    .data_1_i(data_1_i), .data_2_i(data_2_i), .valid_o(valid_o),
    .data_sum_o(data_sum_o), .ovf_o(ovf_o), .unf_o(unf_o)
  );

  always #5 clk_i = ~clk_i;

  // Count enabled edges so latency is measured in en_i-qualified cycles.
  always @(posedge clk_i) begin
    last_en <= en_i;
    if (en_i) cyc <= cyc + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Exact reference: operands as integers scaled by 2^(exp-1), then RNE to 7 significant bits.
  function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b, input logic s);
    longint va, vb, sum, m, q, rem, half;
    int     p, sh, e;
    logic   sg;
    va = (a[10:6] == 5'd0) ? 64'sd0 : (longint'({1'b1, a[5:0]}) <<< (int'(a[10:6]) - 1));
    vb = (b[10:6] == 5'd0) ? 64'sd0 : (longint'({1'b1, b[5:0]}) <<< (int'(b[10:6]) - 1));
    if (a[11]) va = -va;
    if (b[11] ^ s) vb = -vb;
    sum = va + vb;
    if (sum == 0) return 14'd0;
    sg = (sum < 0);
    m  = sg ? -sum : sum;
    p  = 0;
    for (int i = 0; i < 63; i++) if (m[i]) p = i;
    sh = p - 6;
    if (sh > 0) begin
      q    = m >>> sh;
      rem  = m - (q <<< sh);
      half = 64'sd1 <<< (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      if (q == 128) begin
        q  = 64;
        sh = sh + 1;
      end
    end else begin
      q = m <<< (-sh);
    end
    e = sh + 1;
    if (e < 1) return {12'h000, 1'b0, 1'b1};
    if (e > 31) return {sg, 11'h7FF, 2'b10};
    return {sg, 5'(e), 6'(q), 2'b00};
  endfunction

  // Drive one operation for the coming edge and queue its expected result.
  task automatic issue(input logic [11:0] a, input logic [11:0] b, input logic s);
    valid_i  = 1'b1;
    data_1_i = a;
    data_2_i = b;
    sub_i    = s;
    exp_q.push_back(model(a, b, s));
    cyc_q.push_back(cyc + 4);
  endtask

  task automatic test_reset();
    rst_i   = 1'b1;
    en_i    = 1'b1;
    valid_i = 1'b0;
    repeat (3) @(negedge clk_i);
    rst_i = 1'b0;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b required 0", valid_o); end
    n_cmp++; if (data_sum_o !== 12'h000) begin n_bad++; $display("FAIL reset_data: got %h required 000", data_sum_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b required 0", ovf_o); end
    n_cmp++; if (unf_o !== 1'b0) begin n_bad++; $display("FAIL reset_unf: got %b required 0", unf_o); end
    last_out = '0;
  endtask

  task automatic test_directed();
    logic [24:0] vec [11] = '{
      {1'b0, 12'h3C0, 12'h3C0}, {1'b1, 12'h3C0, 12'h3C0}, {1'b0, 12'h3C0, 12'hBC0},
      {1'b0, 12'h3C0, 12'h200}, {1'b0, 12'h3C1, 12'h200}, {1'b0, 12'h7FF, 12'h7FF},
      {1'b0, 12'hFFF, 12'hFFF}, {1'b1, 12'h041, 12'h040}, {1'b0, 12'h3C0, 12'h000},
      {1'b1, 12'h000, 12'h3C0}, {1'b0, 12'h800, 12'hC55}};
    logic [13:0] got, want;
    int          wc;
    en_i = 1'b1;
    for (int i = 0; i < 11 + 12; i++) begin
      @(negedge clk_i);
      if (last_en && valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL directed_spurious: valid_o=1 with nothing outstanding");
        end else begin
          got = {data_sum_o, ovf_o, unf_o}; want = exp_q.pop_front(); wc = cyc_q.pop_front();
          last_out = want;
          if (got !== want || cyc !== wc) begin
            n_bad++;
            $display("FAIL directed: got %h ovf %b unf %b at cycle %0d, required %h ovf %b unf %b at cycle %0d",
                     got[13:2], got[1], got[0], cyc, want[13:2], want[1], want[0], wc);
          end
        end
      end
      if (i < 11) issue(vec[i][23:12], vec[i][11:0], vec[i][24]);
      else valid_i = 1'b0;
      if (i >= 11 && exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL directed_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); cyc_q.delete();
    end
  endtask

  task automatic test_back_to_back();
    logic [13:0] got, want;
    int          wc, n_out, first_c, last_c;
    n_out = 0; first_c = 0; last_c = 0;
    en_i  = 1'b1;
    for (int i = 0; i < 8 + 12; i++) begin
      @(negedge clk_i);
      if (last_en && valid_o) begin
        n_cmp++;
        if (n_out == 0) first_c = cyc;
        last_c = cyc;
        n_out++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL b2b_spurious: valid_o=1 with nothing outstanding");
        end else begin
          got = {data_sum_o, ovf_o, unf_o}; want = exp_q.pop_front(); wc = cyc_q.pop_front();
          last_out = want;
          if (got !== want || cyc !== wc) begin
            n_bad++;
            $display("FAIL b2b: got %h ovf %b unf %b at cycle %0d, required %h ovf %b unf %b at cycle %0d",
                     got[13:2], got[1], got[0], cyc, want[13:2], want[1], want[0], wc);
          end
        end
      end
      if (i < 8) issue(12'h3C0 + 12'(i * 5), 12'h380 + 12'(i * 7), 1'(i & 1));
      else valid_i = 1'b0;
      if (i >= 8 && exp_q.size() == 0) break;
    end
    n_cmp++;
    if (n_out !== 8 || last_c - first_c !== 7) begin
      n_bad++; $display("FAIL b2b_stream: %0d outputs over %0d cycles, required 8 over 7", n_out, last_c - first_c);
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL b2b_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); cyc_q.delete();
    end
  endtask

  task automatic test_random();
    logic [13:0] got, want;
    logic [11:0] a, b;
    int          wc;
    for (int i = 0; i < 80 + 16; i++) begin
      @(negedge clk_i);
      if (last_en && valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL random_spurious: valid_o=1 with nothing outstanding");
        end else begin
          got = {data_sum_o, ovf_o, unf_o}; want = exp_q.pop_front(); wc = cyc_q.pop_front();
          last_out = want;
          if (got !== want || cyc !== wc) begin
            n_bad++;
            $display("FAIL random: got %h ovf %b unf %b at cycle %0d, required %h ovf %b unf %b at cycle %0d",
                     got[13:2], got[1], got[0], cyc, want[13:2], want[1], want[0], wc);
          end
        end
      end else begin
        n_cmp++;
        if ({data_sum_o, ovf_o, unf_o} !== last_out) begin
          n_bad++;
          $display("FAIL random_hold: got %h ovf %b unf %b, required %h ovf %b unf %b",
                   data_sum_o, ovf_o, unf_o, last_out[13:2], last_out[1], last_out[0]);
        end
      end
      a = 12'($urandom);
      case ($urandom_range(0, 3))
        0:       b = {~a[11], a[10:2], a[1:0] ^ 2'($urandom)};
        1:       b = {1'($urandom), a[10:6] - 5'($urandom_range(0, 3)), 6'($urandom)};
        2:       b = {1'($urandom), a[10:6] - 5'($urandom_range(6, 12)), 6'($urandom)};
        default: b = 12'($urandom);
      endcase
      if (i >= 80) begin
        en_i = 1'b1; valid_i = 1'b0;
        if (exp_q.size() == 0) break;
      end else if ($urandom_range(0, 3) == 0) begin
        en_i = 1'b0; valid_i = 1'b1; data_1_i = a; data_2_i = b; sub_i = 1'($urandom);
      end else begin
        en_i = 1'b1;
        if ($urandom_range(0, 3) != 0) issue(a, b, 1'($urandom));
        else valid_i = 1'b0;
      end
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL random_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); cyc_q.delete();
    end
  endtask

  task automatic test_stall_reset();
    logic [13:0] got, want;
    int          wc;
    en_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      issue(12'h3C0, 12'h3C0 + 12'(i), 1'b0);
    end
    @(negedge clk_i);
    en_i = 1'b0; valid_i = 1'b1; data_1_i = 12'h7FF; data_2_i = 12'h7FF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (valid_o !== 1'b0) begin n_bad++; $display("FAIL stall_valid: got %b required 0 (stall %0d)", valid_o, i); end
    end
    rst_i = 1'b1;
    @(negedge clk_i);
    rst_i = 1'b0; en_i = 1'b1; valid_i = 1'b0;
    exp_q.delete(); cyc_q.delete();
    last_out = '0;
    n_cmp++; if (valid_o !== 1'b0) begin n_bad++; $display("FAIL rst_valid: got %b required 0", valid_o); end
    n_cmp++; if (data_sum_o !== 12'h000) begin n_bad++; $display("FAIL rst_data: got %h required 000", data_sum_o); end
    n_cmp++; if (ovf_o !== 1'b0) begin n_bad++; $display("FAIL rst_ovf: got %b required 0", ovf_o); end
    n_cmp++; if (unf_o !== 1'b0) begin n_bad++; $display("FAIL rst_unf: got %b required 0", unf_o); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk_i);
      n_cmp++;
      if (valid_o !== 1'b0) begin n_bad++; $display("FAIL post_rst_valid: got %b required 0 (cycle %0d)", valid_o, i); end
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_i);
      if (last_en && valid_o) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++; $display("FAIL post_rst_spurious: valid_o=1 with nothing outstanding");
        end else begin
          got = {data_sum_o, ovf_o, unf_o}; want = exp_q.pop_front(); wc = cyc_q.pop_front();
          last_out = want;
          if (got !== want || cyc !== wc) begin
            n_bad++;
            $display("FAIL post_rst_op: got %h ovf %b unf %b at cycle %0d, required %h ovf %b unf %b at cycle %0d",
                     got[13:2], got[1], got[0], cyc, want[13:2], want[1], want[0], wc);
          end
        end
      end
      if (i == 0) issue(12'h3C0, 12'h3C0, 1'b0);
      else valid_i = 1'b0;
      if (i > 0 && exp_q.size() == 0) break;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL post_rst_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete(); cyc_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_stall_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/float_add_sub_p.md
FLOAT_ADD_SUB_P -- requirements
Module: float_add_sub_p

Interface
REQ-001 The block SHALL have parameter EXP_W, default 5, exponent field width (3..8).
REQ-002 The block SHALL have parameter MAN_W, default 6, stored mantissa field width (3..23); word width W = 1+EXP_W+MAN_W.
REQ-003 clk_i  input  1  single clock; all state updates on rising edge.
REQ-004 rst_i  input  1  synchronous, active-high reset.
REQ-005 en_i  input  1  pipeline advance enable; 0 freezes every stage.
REQ-006 valid_i  input  1  operands valid this cycle.
REQ-007 sub_i  input  1  0 = a+b, 1 = a-b (b sign inverted).
REQ-008 data_1_i  input  W  operand a {sign, exp, man}.
REQ-009 data_2_i  input  W  operand b, same format.
REQ-010 valid_o  output  1  result valid.
REQ-011 data_sum_o  output  W  result {sign, exp, man}.
REQ-012 ovf_o  output  1  result saturated (qualified by valid_o).
REQ-013 unf_o  output  1  nonzero result flushed to zero (qualified by valid_o).

Function
REQ-014 Format SHALL be: bias 2^(EXP_W-1)-1; exp field 0 = zero regardless of mantissa; exp 1..all-ones = normal with hidden 1; no denormals, Inf or NaN.
REQ-015 The pipeline SHALL be fully pipelined: one operation accepted per cycle while en_i=1, fixed latency 4 en_i-qualified cycles from valid_i to valid_o.
REQ-016 Stage 1 SHALL apply sub_i to b's sign, compare magnitudes ({exp,man} unsigned), and swap so the larger operand is the first.
REQ-017 Stage 2 SHALL right-shift the smaller significand by the exponent difference into MAN_W+4 bits (hidden, MAN_W, guard, round, sticky); shifted-out bits OR into sticky; a difference >= MAN_W+3 SHALL leave only sticky set if the operand is nonzero.
REQ-018 Stage 3 SHALL add significands for equal effective signs and subtract the smaller from the larger otherwise; result sign = larger operand's sign.
REQ-019 Stage 4 SHALL normalise with a leading-one detector (1 right or up to MAN_W+1 left) and adjust the exponent in EXP_W+2 signed bits.
REQ-020 Rounding SHALL be round-to-nearest, ties-to-even, on guard/round/sticky; mantissa carry-out SHALL increment the exponent.
REQ-021 An exact zero sum SHALL give +0 (all bits 0), ovf_o=0, unf_o=0, including x-x.
REQ-022 A zero operand SHALL pass the other operand (sign-adjusted for b) through unchanged.
REQ-023 Final exponent > all-ones SHALL give the max-magnitude value of the result sign (exp and man all ones) with ovf_o=1.
REQ-024 Final exponent < 1 with a nonzero significand SHALL give +0 with unf_o=1.
REQ-025 With en_i=0, all stage registers and outputs SHALL hold; valid_i and data inputs are ignored that cycle.
REQ-026 When valid_o=0, data_sum_o, ovf_o and unf_o SHALL hold their last valid values.
REQ-027 Valid SHALL propagate through a per-stage valid bit; the datapath MAY toggle on invalid slots, but outputs update only on valid slots.

Reset
REQ-028 rst_i=1 at a clock edge SHALL clear all stage valid bits, valid_o, data_sum_o, ovf_o and unf_o to 0, regardless of en_i.
REQ-029 Operations in flight when reset is asserted SHALL be discarded; none SHALL appear at valid_o after reset deasserts.
REQ-030 The first valid_i accepted after reset deassertion SHALL produce valid_o exactly 4 enabled cycles later.

Verification (defaults EXP_W=5, MAN_W=6, hex = 12-bit word)
REQ-031 0x3C0 + 0x3C0, sub_i=0 -> 0x400 at cycle +4, flags 0; back-to-back stream of 8 ops -> 8 consecutive valid_o.
REQ-032 0x3C0 with sub_i=1 and 0x3C0 -> 0x000, flags 0; 0x3C0 + 0xBC0 -> 0x000.
REQ-033 Tie rounding: 0x3C0 + 0x200 -> 0x3C0; 0x3C1 + 0x200 -> 0x3C2.
REQ-034 0x7FF + 0x7FF -> 0x7FF, ovf_o=1; 0xFFF + 0xFFF -> 0xFFF, ovf_o=1.
REQ-035 0x041 with sub_i=1 and 0x040 -> 0x000, unf_o=1; 0x3C0 + 0x000 -> 0x3C0.
REQ-036 Issue 3 ops, hold en_i=0 for 5 cycles, then assert rst_i for 1 cycle -> no valid_o during the stall or after reset; the next op appears 4 cycles after acceptance.
